fpu_op_scheduler: RTL

Two-requester issue controller for the single-precision FPU `ALU` (adder and multiplier behind a 1-bit opcode mux). It accepts add/mul requests from two independent clients and arbitrates between them round-robin. It issues one operation at a time, holds the ALU opcode stable until the selected unit's result returns, and delivers the result, tagged with the requester ID, on a valid/ready response channel. A watchdog counter guarantees forward progress if a result never arrives.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/rr_arbiter_2.sv | 18 +
 rtl/fpu_op_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue path.
package fpu_pkg;

  localparam int FP_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            op;
  } fp_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; a lone requester always wins, ties go to rr_ptr.
module rr_arbiter_2 (
  input  logic [1:0] vld,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (vld)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Single-outstanding add/mul issue controller for two clients, with a
// watchdog that forces a timeout response if the ALU never answers.
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_vld,
  output logic            req0_rdy,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req0_op,
  input  logic            req1_vld,
  output logic            req1_rdy,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  input  logic            req1_op,
  output logic            alu_i_vld,
  output logic [FP_W-1:0] alu_i_a,
  output logic [FP_W-1:0] alu_i_b,
  output logic            alu_opcode,
  input  logic [FP_W-1:0] alu_o_res,
  input  logic            alu_o_res_vld,
  input  logic            alu_overflow,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic            rsp_id,
  output logic [FP_W-1:0] rsp_res,
  output logic            rsp_overflow,
  output logic            rsp_timeout,
  output logic            busy
);

  state_e          state;
  logic            rr_ptr;
  logic            cur_id;
  logic [TO_W-1:0] wd_cnt;
  logic [1:0]      gnt;
  fp_req_t         req_sel;
  logic            wd_expire;

  rr_arbiter_2 u_arb (
    .vld    ({req1_vld, req0_vld}),
    .rr_ptr (rr_ptr),
    .gnt    (gnt)
  );

  // Ready is only offered while idle; reset gating keeps it low during rst.
  assign req0_rdy  = (state == IDLE) && !rst && gnt[0];
  assign req1_rdy  = (state == IDLE) && !rst && gnt[1];
  assign busy      = (state != IDLE);
  assign wd_expire = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_sel = gnt[1] ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      cur_id       <= 1'b0;
      wd_cnt       <= '0;
      alu_i_vld    <= 1'b0;
      alu_i_a      <= '0;
      alu_i_b      <= '0;
      alu_opcode   <= OP_ADD;
      rsp_vld      <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_res      <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            alu_i_a    <= req_sel.a;
            alu_i_b    <= req_sel.b;
            alu_opcode <= req_sel.op;
            cur_id     <= gnt[1];
            alu_i_vld  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          alu_i_vld <= 1'b0;
          wd_cnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A result landing on the expiry cycle still counts as a result.
          if (alu_o_res_vld) begin
            rsp_res      <= alu_o_res;
            rsp_overflow <= alu_overflow;
            rsp_timeout  <= 1'b0;
            rsp_id       <= cur_id;
            rsp_vld      <= 1'b1;
            state        <= RESP;
          end else if (wd_expire) begin
            rsp_res      <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_id       <= cur_id;
            rsp_vld      <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            rr_ptr  <= ~rsp_id;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
